// File: rtl/seven_seg_driver_if.sv
// seven_seg_driver_if: display-code input and cathode/anode outputs of the
// four-digit seven-segment scanner. The master side supplies codes and
// watches the pins. The slave side is the driver.
// Optional feature macro: SEG_DIM_EN adds the 2-bit brightness signal.
interface seven_seg_driver_if;
  logic [15:0] display_code;
`ifdef SEG_DIM_EN
  logic [1:0]  brightness;
`endif
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  modport master (
`ifdef SEG_DIM_EN
    output brightness,
`endif
    output display_code,
    input  seg, an, dp
  );

  modport slave (
`ifdef SEG_DIM_EN
    input  brightness,
`endif
    input  display_code,
    output seg, an, dp
  );
endinterface

// File: rtl/seven_seg_driver.sv
// seven_seg_driver: time-multiplexed driver for a four-digit common-anode
// seven-segment display. A prescaler divides each digit slot into
// REFRESH_DIV cycles. The first BLANK_CYCLES of each slot keep every anode
// off to avoid ghosting. Digit codes are latched once per frame so that a
// single scan never mixes old and new digits.
// Optional feature macro: SEG_DIM_EN adds a 2-bit brightness input that
// widens the anode-off window. brightness=3 gives full brightness.
module seven_seg_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  seven_seg_driver_if.slave bus
);

  localparam int unsigned      CNT_W       = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [15:0]      FRAME_BLANK = 16'hEEEE;
  localparam logic [6:0]       GLYPH_OFF   = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}. Codes without a glyph show nothing.
  function automatic logic [6:0] decode_glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hC:    g = 7'b0000110;
      4'hD:    g = 7'b0101111;
      default: g = GLYPH_OFF;
    endcase
    return g;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      frame;
  logic             tick;
  logic [31:0]      off_lim;
  logic [3:0]       digit_p0;
  logic [6:0]       seg_p0;
  logic [3:0]       an_p0;
`ifdef SEG_DIM_EN
  logic [31:0]      dim_lim;
`endif

  assign tick = (cnt == CNT_LAST);

  // Prescaler, digit index and once-per-frame capture of the display codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= 2'd0;
      frame <= FRAME_BLANK;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        idx <= idx + 2'd1;
      end
      if (tick && (idx == 2'd3)) begin
        frame <= bus.display_code;
      end
    end
  end

  // End of the anode-off window at the start of each slot.
  always_comb begin
    off_lim = BLANK_CYCLES;
`ifdef SEG_DIM_EN
    dim_lim = REFRESH_DIV - (((32'(bus.brightness) + 32'd1) * REFRESH_DIV) >> 2);
    if (dim_lim > off_lim) begin
      off_lim = dim_lim;
    end
`endif
  end

  // ---- stage p0: select the current digit, decode it and pick the anode
  always_comb begin
    digit_p0 = frame[{idx, 2'b00} +: 4];
    seg_p0   = decode_glyph(digit_p0);
    an_p0    = 4'b1111;
    if (32'(cnt) >= off_lim) begin
      an_p0 = ~(4'b0001 << idx);
    end
  end

  // ---- stage p1: register the cathodes and anodes together onto the pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.seg <= GLYPH_OFF;
      bus.an  <= 4'b1111;
      bus.dp  <= 1'b1;
    end else begin
      bus.seg <= seg_p0;
      bus.an  <= an_p0;
      bus.dp  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_driver.sv
// tb_seven_seg_driver: directed scan-sequence bench for seven_seg_driver
// with REFRESH_DIV=8 and BLANK_CYCLES=2.
module tb_seven_seg_driver;

  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;

  localparam logic [6:0] G0  = 7'b1000000;
  localparam logic [6:0] G1  = 7'b1111001;
  localparam logic [6:0] G2  = 7'b0100100;
  localparam logic [6:0] G3  = 7'b0110000;
  localparam logic [6:0] G4  = 7'b0011001;
  localparam logic [6:0] G5  = 7'b0010010;
  localparam logic [6:0] G6  = 7'b0000010;
  localparam logic [6:0] G7  = 7'b1111000;
  localparam logic [6:0] G8  = 7'b0000000;
  localparam logic [6:0] G9  = 7'b0010000;
  localparam logic [6:0] GE  = 7'b0000110;
  localparam logic [6:0] GR  = 7'b0101111;
  localparam logic [6:0] GBL = 7'b1111111;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  seven_seg_driver_if bus ();

  seven_seg_driver #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Walk one full frame (4 slots of RD cycles), sampling on the falling edge.
  // glyphs = {slot3, slot2, slot1, slot0}. When the slot/cycle match,
  // display_code changes to chg_code right after that sample.
  task automatic run_frame(input string tag, input logic [27:0] glyphs, input int nblank,
                           input int chg_slot, input int chg_cyc, input logic [15:0] chg_code);
    logic [3:0] an_tab [4];
    an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < int'(RD); c++) begin
        @(posedge clk);
        @(negedge clk);
        if (c < nblank) begin
          chk($sformatf("%s_s%0d_c%0d_an_off", tag, s, c), {3'b000, bus.an}, 7'h0F);
        end else begin
          chk($sformatf("%s_s%0d_c%0d_an", tag, s, c), {3'b000, bus.an}, {3'b000, an_tab[s]});
          chk($sformatf("%s_s%0d_c%0d_seg", tag, s, c), bus.seg, glyphs[7*s +: 7]);
        end
        chk($sformatf("%s_s%0d_c%0d_dp", tag, s, c), {6'd0, bus.dp}, 7'd1);
        if (s == chg_slot && c == chg_cyc) begin
          bus.display_code = chg_code;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.display_code = 16'h0000;
`ifdef SEG_DIM_EN
    bus.brightness = 2'd3;
`endif
    repeat (3) @(negedge clk);
    chk("reset_seg", bus.seg, GBL);
    chk("reset_an", {3'b000, bus.an}, 7'h0F);
    chk("reset_dp", {6'd0, bus.dp}, 7'd1);

    bus.display_code = 16'h1234;
    rst = 1'b0;
    run_frame("f0_blank", {GBL, GBL, GBL, GBL}, BC, -1, 0, 16'h0000);
    run_frame("f1_1234",  {G1, G2, G3, G4},     BC, -1, 0, 16'h0000);
    run_frame("f2_1234",  {G1, G2, G3, G4},     BC, 1, 3, 16'h5678);
    run_frame("f3_5678",  {G5, G6, G7, G8},     BC, 2, 4, 16'hECDD);
    run_frame("f4_ecdd",  {GBL, GE, GR, GR},    BC, 0, 5, 16'h3210);
    run_frame("f5_3210",  {G3, G2, G1, G0},     BC, 1, 0, 16'h7654);
    run_frame("f6_7654",  {G7, G6, G5, G4},     BC, 2, 6, 16'hBA98);
    run_frame("f7_ba98",  {GBL, GBL, G9, G8},   BC, 3, 2, 16'hFEDC);
    run_frame("f8_fedc",  {GBL, GBL, GR, GE},   BC, 0, 0, 16'h0000);

    // Part way into slot 0 of a frame showing 0000, then reset mid-slot.
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_an", {3'b000, bus.an}, 7'b0001110);
    chk("pre_rst_seg", bus.seg, G0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_seg", bus.seg, GBL);
    chk("async_rst_an", {3'b000, bus.an}, 7'h0F);
    chk("async_rst_dp", {6'd0, bus.dp}, 7'd1);
    @(posedge clk);
    @(negedge clk);
    chk("held_rst_an", {3'b000, bus.an}, 7'h0F);
    chk("held_rst_seg", bus.seg, GBL);

    bus.display_code = 16'h1234;
    rst = 1'b0;
    run_frame("post_rst_blank", {GBL, GBL, GBL, GBL}, BC, -1, 0, 16'h0000);
    run_frame("post_rst_1234",  {G1, G2, G3, G4},     BC, -1, 0, 16'h0000);

`ifdef SEG_DIM_EN
    bus.brightness = 2'd0;
    run_frame("dim_b0", {G1, G2, G3, G4}, 6, -1, 0, 16'h0000);
    bus.brightness = 2'd3;
    run_frame("dim_b3", {G1, G2, G3, G4}, BC, -1, 0, 16'h0000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seven_seg_driver.md
SEVEN_SEG_DRIVER -- requirements
Module: seven_seg_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clock cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16, anode-off cycles at the start of each slot (legal range 0..REFRESH_DIV-2).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port display_code  input  16  four 4-bit digit codes from the display mux; [15:12] is leftmost.
REQ-006 SHALL have port seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-007 SHALL have port an  output  4  anodes, active-low, registered; an[3] is leftmost, an[0] is rightmost.
REQ-008 SHALL have port dp  output  1  decimal point, active-low; held 1.

Function
REQ-009 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; "tick" is count==REFRESH_DIV-1.
REQ-010 SHALL hold a 2-bit digit index that increments on tick and wraps 3->0; scan order is 0,1,2,3 (an[0] first).
REQ-011 SHALL capture display_code into a frame register only on a tick with index==3, so a frame never mixes old and new digits.
REQ-012 SHALL take digit i from frame register bits [4i+3:4i].
REQ-013 SHALL decode digit codes as follows: 0x0-0x9 to decimal glyphs, 0xC to 'E' (0000110), 0xD to 'r' (0101111), 0xE to blank (1111111), and 0xA/0xB/0xF to blank.
REQ-014 SHALL use these glyph values: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-015 SHALL drive an to 1111 while prescaler count < BLANK_CYCLES, and otherwise drive exactly one anode low: an[index].
REQ-016 SHALL register seg and an together, reflecting the prescaler, index and frame state of the previous cycle (one-cycle latency); an SHALL never have more than one bit low.
REQ-017 SHALL treat BLANK_CYCLES=0 as no blanking, with the anode low for the full slot.
REQ-018 SHALL NOT let mid-frame changes of display_code alter seg until the next capture.

Reset
REQ-019 SHALL, while rst=1, asynchronously force prescaler=0, index=0, frame register=0xEEEE (all blank), seg=1111111, an=1111 and dp=1.
REQ-020 SHALL, after rst deasserts, start at slot 0 with prescaler 0; the first capture occurs at the end of slot 3, so the display is blank for the first frame.
REQ-021 SHALL, on reset asserted mid-slot or mid-frame, abandon the slot with no partial glyph and force outputs per REQ-019 in the same cycle reset asserts.

Configuration
REQ-022 SHALL support macro SEG_DIM_EN; when defined, the block SHALL add input port brightness (2 bits, after display_code) and lengthen the anode-off window to count < max(BLANK_CYCLES, REFRESH_DIV - ((brightness+1)*REFRESH_DIV)/4).
REQ-023 SHALL, when SEG_DIM_EN is defined, make brightness=3 behave identically to the undefined build, and sample brightness every cycle with no frame latching.
REQ-024 SHALL, when SEG_DIM_EN is undefined, have no brightness port and no dimming logic.

Verification (REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-025 SHALL cover: rst pulse mid-slot -> seg=1111111 and an=1111 in the same cycle; after release, an stays 1111 for 2 cycles, then digits show blank through the first frame.
REQ-026 SHALL cover: display_code=0x1234 held -> after the first capture, the per-slot sequence an=1110/seg=0011001, an=1101/0110000, an=1011/0100100, an=0111/1111001, each slot low for 6 of 8 cycles.
REQ-027 SHALL cover: display_code=0xECDD ("blank E r r") -> an[3] slot seg=1111111, an[2]=0000110, an[1]=0101111, an[0]=0101111.
REQ-028 SHALL cover: display_code changed from 0x1234 to 0x5678 during slot 1 -> remaining slots keep 1234 glyphs and the next frame shows 5678.
REQ-029 SHALL cover: all codes 0x0-0xF per slot -> glyphs match REQ-013/REQ-014, and an is never observed with two bits low.
REQ-030 SHALL cover, with SEG_DIM_EN defined: brightness=0 -> anode low only for counts 6..7 of each slot; brightness=3 -> counts 2..7.
